// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO burst drain: FSM state encoding and the stats counter width.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        DRN_IDLE,
        DRN_HOLD,
        DRN_SEND
    } drn_state_t;

    localparam int BURST_CNT_W = 16;

endpackage

// File: rtl/fifo_burst_drain.sv
// Drains a show-ahead FIFO onto a valid/ready stream framed into bursts of up to BURST_LEN beats.
// Optional FIFO_DRAIN_STATS_EN adds a wrapping completed-burst counter on burst_cnt.
module fifo_burst_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_LEN     = 16,
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_rdata,
    output logic                   fifo_ren,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
`ifdef FIFO_DRAIN_STATS_EN
    output logic                   m_last,
    output logic [BURST_CNT_W-1:0] burst_cnt
`else
    output logic                   m_last
`endif
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(FLUSH_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = '1;

    drn_state_t            state;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  pop;

    // NOTE: every variable gets a default before the case so this block cannot infer a latch.
    always_comb begin
        pop = 1'b0;
        if (!rst && !fifo_empty) begin
            case (state)
                DRN_IDLE: pop = 1'b1;
                DRN_SEND: pop = m_ready;
                default:  pop = 1'b0;
            endcase
        end
    end

    assign fifo_ren = pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DRN_IDLE;
            hold_data <= '0;
            beat_cnt  <= '0;
            idle_cnt  <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
        end else begin
            case (state)
                DRN_IDLE: begin
                    if (pop) begin
                        hold_data <= fifo_rdata;
                        idle_cnt  <= '0;
                        state     <= DRN_HOLD;
                    end
                end

                // The held word is only released once we know whether it ends the burst.
                DRN_HOLD: begin
                    if (beat_cnt == LAST_BEAT || flush) begin
                        m_valid <= 1'b1;
                        m_data  <= hold_data;
                        m_last  <= 1'b1;
                        state   <= DRN_SEND;
                    end else if (!fifo_empty) begin
                        m_valid <= 1'b1;
                        m_data  <= hold_data;
                        m_last  <= 1'b0;
                        state   <= DRN_SEND;
                    end else if (idle_cnt == IDLE_LIMIT) begin
                        m_valid <= 1'b1;
                        m_data  <= hold_data;
                        m_last  <= 1'b1;
                        state   <= DRN_SEND;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                DRN_SEND: begin
                    if (m_ready) begin
                        m_valid  <= 1'b0;
                        m_last   <= 1'b0;
                        beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
                        if (pop) begin
                            hold_data <= fifo_rdata;
                            idle_cnt  <= '0;
                            state     <= DRN_HOLD;
                        end else begin
                            state <= DRN_IDLE;
                        end
                    end
                end

                default: state <= DRN_IDLE;
            endcase
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (m_valid && m_ready && m_last) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end
`endif

endmodule
